program_loader: RTL and testbench

- Bus-master controller that fills the 16-byte program RAM from an external byte stream while the CPU is held.
- Takes over the 8-bit bus and the 16-bit control word. It asserts cpu_hold, which the top level wires to the instruction decoder enable (inverted). It then sequences MEMORY_ADDRESS_IN / RAM_IN writes and ends with a one-cycle CPU clear pulse, so the program counter, instruction register and microstep counter restart at 0.

---
 rtl/program_loader_pkg.sv | 54 +++++
 rtl/program_loader.sv | 174 +++++++++++++++++
 tb/tb_program_loader.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared control-word definitions and loader types for the program RAM loader.
// LOADER_CHECKSUM_EN adds the WAIT_CHK state used by the checksum variant.
package program_loader_pkg;

    localparam int unsigned LOADER_CW_WIDTH = 16;
    localparam int unsigned BUS_WIDTH       = 8;

    // Control-word bit indices
    localparam int unsigned HLT               = 15;
    localparam int unsigned MEMORY_ADDRESS_IN = 14;
    localparam int unsigned RAM_IN            = 13;
    localparam int unsigned RAM_OUT           = 12;
    localparam int unsigned IR_OUT            = 11;
    localparam int unsigned IR_IN             = 10;
    localparam int unsigned A_IN              = 9;
    localparam int unsigned A_OUT             = 8;
    localparam int unsigned SUM_OUT           = 7;
    localparam int unsigned SUBTRACT          = 6;
    localparam int unsigned B_IN              = 5;
    localparam int unsigned OUT_IN            = 4;
    localparam int unsigned COUNTER_ENABLE    = 3;
    localparam int unsigned COUNTER_OUT       = 2;
    localparam int unsigned JUMP              = 1;
    localparam int unsigned FLAGS_IN          = 0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_BYTE = 3'd1,
        ST_SET_ADDR  = 3'd2,
        ST_WRITE     = 3'd3,
        ST_CLEAR_CPU = 3'd4,
        ST_DONE      = 3'd5
`ifdef LOADER_CHECKSUM_EN
        ,
        ST_WAIT_CHK  = 3'd6
`endif
    } loader_state_t;

    typedef struct packed {
        logic                       byte_ready;
        logic                       cpu_hold;
        logic                       cpu_clear;
        logic                       busy;
        logic                       done;
        logic                       bus_en;
        logic [BUS_WIDTH-1:0]       bus;
        logic [LOADER_CW_WIDTH-1:0] cw;
    } loader_out_t;

    function automatic logic [LOADER_CW_WIDTH-1:0] cw_bit(input int unsigned idx);
        return LOADER_CW_WIDTH'(1) << idx;
    endfunction

endpackage

// File: rtl/program_loader.sv
// Bus-master loader: holds the CPU, streams bytes into program RAM, then clears the CPU.
// Define LOADER_CHECKSUM_EN to require a trailing modulo-256 checksum byte.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned LOAD_DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       clear_n,
    input  logic                       start,
    input  logic                       byte_valid,
    input  logic [BUS_WIDTH-1:0]       byte_data,
    output logic                       byte_ready,
    output logic [BUS_WIDTH-1:0]       bus_out,
    output logic [LOADER_CW_WIDTH-1:0] control_word_out,
    output logic                       cpu_hold,
    output logic                       cpu_clear,
    output logic                       busy,
    output logic                       done,
    output logic                       checksum_error
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LOAD_DEPTH - 1);

    loader_state_t          state, state_next;
    logic [ADDR_WIDTH-1:0]  addr, addr_next;
    logic [BUS_WIDTH-1:0]   data, data_next;
    loader_out_t            out_q, out_next;
    logic                   accept;

`ifdef LOADER_CHECKSUM_EN
    logic [BUS_WIDTH-1:0]   sum, sum_next;
    logic                   err, err_next;
`endif

    assign accept = byte_valid && out_q.byte_ready;

    // State, counter, latch and registered output decode
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state <= ST_IDLE;
            addr  <= '0;
            data  <= '0;
            out_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum   <= '0;
            err   <= 1'b0;
`endif
        end else begin
            state <= state_next;
            addr  <= addr_next;
            data  <= data_next;
            out_q <= out_next;
`ifdef LOADER_CHECKSUM_EN
            sum   <= sum_next;
            err   <= err_next;
`endif
        end
    end

    // Next-state logic, then outputs decoded from the next state so they register with it
    always_comb begin
        state_next = state;
        addr_next  = addr;
        data_next  = data;
        out_next   = '0;
`ifdef LOADER_CHECKSUM_EN
        sum_next   = sum;
        err_next   = err;
`endif

        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = ST_WAIT_BYTE;
                    addr_next  = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_next   = '0;
                    err_next   = 1'b0;
`endif
                end
            end
            ST_WAIT_BYTE: begin
                if (accept) begin
                    data_next  = byte_data;
                    state_next = ST_SET_ADDR;
`ifdef LOADER_CHECKSUM_EN
                    sum_next   = sum + byte_data;
`endif
                end
            end
            ST_SET_ADDR: state_next = ST_WRITE;
            ST_WRITE: begin
                if (addr == LAST_ADDR) begin
`ifdef LOADER_CHECKSUM_EN
                    state_next = ST_WAIT_CHK;
`else
                    state_next = ST_CLEAR_CPU;
`endif
                end else begin
                    addr_next  = addr + ADDR_WIDTH'(1);
                    state_next = ST_WAIT_BYTE;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_WAIT_CHK: begin
                if (accept) begin
                    if (byte_data == sum) begin
                        state_next = ST_CLEAR_CPU;
                    end else begin
                        state_next = ST_DONE;
                        err_next   = 1'b1;
                    end
                end
            end
`endif
            ST_CLEAR_CPU: state_next = ST_DONE;
            default:      state_next = ST_IDLE;
        endcase

        unique case (state_next)
            ST_WAIT_BYTE: begin
                out_next.byte_ready = 1'b1;
                out_next.cpu_hold   = 1'b1;
                out_next.busy       = 1'b1;
            end
            ST_SET_ADDR: begin
                out_next.cpu_hold = 1'b1;
                out_next.busy     = 1'b1;
                out_next.bus_en   = 1'b1;
                out_next.bus      = BUS_WIDTH'(addr_next);
                out_next.cw       = cw_bit(MEMORY_ADDRESS_IN);
            end
            ST_WRITE: begin
                out_next.cpu_hold = 1'b1;
                out_next.busy     = 1'b1;
                out_next.bus_en   = 1'b1;
                out_next.bus      = data_next;
                out_next.cw       = cw_bit(RAM_IN);
            end
`ifdef LOADER_CHECKSUM_EN
            ST_WAIT_CHK: begin
                out_next.byte_ready = 1'b1;
                out_next.cpu_hold   = 1'b1;
                out_next.busy       = 1'b1;
            end
`endif
            ST_CLEAR_CPU: begin
                out_next.cpu_hold  = 1'b1;
                out_next.busy      = 1'b1;
                out_next.cpu_clear = 1'b1;
            end
            ST_DONE: out_next.done = 1'b1;
            default: ;
        endcase
    end

    assign byte_ready       = out_q.byte_ready;
    assign cpu_hold         = out_q.cpu_hold;
    assign cpu_clear        = out_q.cpu_clear;
    assign busy             = out_q.busy;
    assign done             = out_q.done;
    // Control word is owned by the loader whenever the CPU is held
    assign bus_out          = out_q.bus_en   ? out_q.bus : {BUS_WIDTH{1'bz}};
    assign control_word_out = out_q.cpu_hold ? out_q.cw  : {LOADER_CW_WIDTH{1'bz}};

`ifdef LOADER_CHECKSUM_EN
    assign checksum_error = err;
`else
    assign checksum_error = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader with a bus-snooping RAM model.
// Covers the LOADER_CHECKSUM_EN variant when that macro is defined.
module tb_program_loader;
    import program_loader_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam logic [15:0] CW_MAI   = 16'h4000;
    localparam logic [15:0] CW_RAMIN = 16'h2000;
`ifdef LOADER_CHECKSUM_EN
    localparam int unsigned EXTRA = 1;
`else
    localparam int unsigned EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        clear_n;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    wire  [7:0]  bus_out;
    wire  [15:0] control_word_out;
    logic        cpu_hold;
    logic        cpu_clear;
    logic        busy;
    logic        done;
    logic        checksum_error;

    program_loader #(.ADDR_WIDTH(4), .LOAD_DEPTH(DEPTH)) dut (
        .clk              (clk),
        .clear_n          (clear_n),
        .start            (start),
        .byte_valid       (byte_valid),
        .byte_data        (byte_data),
        .byte_ready       (byte_ready),
        .bus_out          (bus_out),
        .control_word_out (control_word_out),
        .cpu_hold         (cpu_hold),
        .cpu_clear        (cpu_clear),
        .busy             (busy),
        .done             (done),
        .checksum_error   (checksum_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Bus snooper: models the MAR/RAM the loader writes through
    logic [7:0] ram [DEPTH];
    logic [3:0] mar = '0;
    int cyc = 0, ram_writes = 0, clear_pulses = 0, ready_cycles = 0, done_rise_cyc = 0;
    logic done_d = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (control_word_out === CW_MAI) mar = bus_out[3:0];
        if (control_word_out === CW_RAMIN) begin
            ram[mar] = bus_out;
            ram_writes++;
        end
        if (cpu_clear === 1'b1) clear_pulses++;
        if (byte_ready === 1'b1) ready_cycles++;
        if (done === 1'b1 && done_d !== 1'b1) done_rise_cyc = cyc;
        done_d = done;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic fill_ram();
        for (int i = 0; i < int'(DEPTH); i++) ram[i] = 8'hEE;
    endtask

    int start_cyc;
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
    endtask

    // Present a byte and return just after the edge that accepts it
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        byte_data  = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        check("ready_wait", 32'(byte_ready), 32'd1);
        tick();
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (done !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        check("done_wait", 32'(done), 32'd1);
    endtask

    task automatic check_released(input string tag);
        check({tag, "_bus_z"}, {24'h0, bus_out}, {24'h0, 8'hzz});
        check({tag, "_cw_z"}, {16'h0, control_word_out}, {16'h0, 16'hzzzz});
        check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    int base_clr, base_rdy, base_wr;
    logic [7:0] sum;

    initial begin
        clear_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = '0;
        fill_ram();
        repeat (2) tick();
        check("rst_ready", 32'(byte_ready), 32'd0);
        check("rst_clear", 32'(cpu_clear), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_chkerr", 32'(checksum_error), 32'd0);
        check_released("rst");
        clear_n = 1'b1;
        tick();

        // Session 1: 0x00..0x0F back-to-back
        base_clr = clear_pulses; base_rdy = ready_cycles;
        pulse_start();
        sum = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            send_byte(8'(i));
            sum = sum + 8'(i);
            if (i == 5) begin
                check("set_addr_bus", 32'(bus_out), 32'h05);
                check("set_addr_cw", 32'(control_word_out), 32'(CW_MAI));
                tick();
                check("write_bus", 32'(bus_out), 32'h05);
                check("write_cw", 32'(control_word_out), 32'(CW_RAMIN));
            end
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(sum);
`endif
        byte_valid = 1'b0;
        wait_done(20);
        for (int i = 0; i < int'(DEPTH); i++) check($sformatf("s1_ram%0d", i), 32'(ram[i]), 32'(i));
        check("s1_clear_pulses", 32'(clear_pulses - base_clr), 32'd1);
        check("s1_ready_cycles", 32'(ready_cycles - base_rdy), 32'(DEPTH + EXTRA));
        check("s1_session_len", 32'(done_rise_cyc - start_cyc + 1), 32'(DEPTH * 3 + 2 + EXTRA));
        check("s1_chkerr", 32'(checksum_error), 32'd0);
        check_released("s1_done");

        // Session 2: stall after byte 3, then reset after byte 7
        fill_ram();
        base_clr = clear_pulses;
        pulse_start();
        check("s2_done_cleared", 32'(done), 32'd0);
        for (int i = 0; i < 4; i++) send_byte(8'h20 + 8'(i));
        byte_valid = 1'b0;
        tick(); tick();
        base_wr = ram_writes;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_ready", 32'(byte_ready), 32'd1);
            check("stall_hold", 32'(cpu_hold), 32'd1);
            check("stall_cw", {16'h0, control_word_out}, 32'h0);
        end
        check("stall_no_writes", 32'(ram_writes - base_wr), 32'd0);
        for (int i = 4; i < 8; i++) send_byte(8'h20 + 8'(i));
        byte_valid = 1'b0;
        check("pre_rst_bus", 32'(bus_out), 32'h07);
        clear_n = 1'b0;
        #1;
        check_released("midrst");
        check("midrst_ready", 32'(byte_ready), 32'd0);
        tick(); tick();
        clear_n = 1'b1;
        tick();
        check("midrst_no_clear", 32'(clear_pulses - base_clr), 32'd0);
        check("midrst_writes", 32'(ram_writes - base_wr), 32'd3);
        check("midrst_ram3", 32'(ram[3]), 32'h23);

        // Session 3: reload from 0 with a stray start mid-session
        fill_ram();
        base_clr = clear_pulses; base_wr = ram_writes;
        pulse_start();
        sum = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (i == 8) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            send_byte(8'hA0 + 8'(i));
            sum = sum + 8'hA0 + 8'(i);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(sum);
`endif
        byte_valid = 1'b0;
        wait_done(20);
        for (int i = 0; i < int'(DEPTH); i++) check($sformatf("s3_ram%0d", i), 32'(ram[i]), 32'hA0 + 32'(i));
        check("s3_writes", 32'(ram_writes - base_wr), 32'(DEPTH));
        check("s3_clear_pulses", 32'(clear_pulses - base_clr), 32'd1);
        check_released("s3_done");

`ifdef LOADER_CHECKSUM_EN
        // Checksum good: 16 x 0x01 sums to 0x10
        base_clr = clear_pulses;
        pulse_start();
        for (int i = 0; i < int'(DEPTH); i++) send_byte(8'h01);
        send_byte(8'h10);
        byte_valid = 1'b0;
        wait_done(20);
        check("chk_ok_clear", 32'(clear_pulses - base_clr), 32'd1);
        check("chk_ok_err", 32'(checksum_error), 32'd0);

        // Checksum bad
        base_clr = clear_pulses;
        pulse_start();
        for (int i = 0; i < int'(DEPTH); i++) send_byte(8'h01);
        send_byte(8'h11);
        byte_valid = 1'b0;
        wait_done(20);
        check("chk_bad_clear", 32'(clear_pulses - base_clr), 32'd0);
        check("chk_bad_err", 32'(checksum_error), 32'd1);
        check("chk_bad_done", 32'(done), 32'd1);
        pulse_start();
        check("chk_err_cleared", 32'(checksum_error), 32'd0);
`else
        check("no_chk_err", 32'(checksum_error), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
